// File: rtl/home_inventory_snapshot_assembler.sv
// Assembles an 8-channel ADC word stream into a timestamped snapshot pulse, and keeps
// saturating frame, sequence-error and timeout counters.
module home_inventory_snapshot_assembler #(
    parameter int unsigned TS_DIV         = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snap_en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_ch,
    input  logic [31:0] in_data,
    output logic        sample_valid,
    output logic [31:0] ts_now,
    output logic [31:0] sample_ch0,
    output logic [31:0] sample_ch1,
    output logic [31:0] sample_ch2,
    output logic [31:0] sample_ch3,
    output logic [31:0] sample_ch4,
    output logic [31:0] sample_ch5,
    output logic [31:0] sample_ch6,
    output logic [31:0] sample_ch7,
    output logic [31:0] ts_counter,
    output logic [31:0] frame_count,
    output logic [15:0] seq_err_count,
    output logic [15:0] timeout_count
);

    typedef enum logic [1:0] {StIdle, StCollect, StPublish} state_e;

    state_e      state;
    logic [31:0] presc;
    logic [31:0] gap;
    logic [31:0] ts_frame;
    logic [2:0]  exp_ch;
    logic [31:0] shadow [8];
    logic        accept;

    assign in_ready = (state != StPublish);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            presc         <= '0;
            gap           <= '0;
            ts_frame      <= '0;
            exp_ch        <= '0;
            for (int i = 0; i < 8; i++) shadow[i] <= '0;
            sample_valid  <= 1'b0;
            ts_now        <= '0;
            sample_ch0    <= '0;
            sample_ch1    <= '0;
            sample_ch2    <= '0;
            sample_ch3    <= '0;
            sample_ch4    <= '0;
            sample_ch5    <= '0;
            sample_ch6    <= '0;
            sample_ch7    <= '0;
            ts_counter    <= '0;
            frame_count   <= '0;
            seq_err_count <= '0;
            timeout_count <= '0;
        end else begin
            // Timestamp runs independently of the assembly enable.
            if (presc == TS_DIV - 1) begin
                presc      <= '0;
                ts_counter <= ts_counter + 32'd1;
            end else begin
                presc <= presc + 32'd1;
            end

            sample_valid <= 1'b0;

            if (state == StPublish) begin
                // The pulse always completes, even if snap_en has just dropped.
                state <= StIdle;
                if (frame_count != '1) frame_count <= frame_count + 32'd1;
            end else if (!snap_en) begin
                state <= StIdle;
                gap   <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        gap <= '0;
                        if (accept) begin
                            if (in_ch == 3'd0) begin
                                shadow[0] <= in_data;
                                ts_frame  <= ts_counter;
                                exp_ch    <= 3'd1;
                                state     <= StCollect;
                            end else if (seq_err_count != '1) begin
                                seq_err_count <= seq_err_count + 16'd1;
                            end
                        end
                    end
                    StCollect: begin
                        if (accept) begin
                            gap <= '0;
                            if (in_ch == 3'd0) begin
                                if (seq_err_count != '1) seq_err_count <= seq_err_count + 16'd1;
                                shadow[0] <= in_data;
                                ts_frame  <= ts_counter;
                                exp_ch    <= 3'd1;
                            end else if (in_ch == exp_ch) begin
                                if (exp_ch == 3'd7) begin
                                    sample_ch0   <= shadow[0];
                                    sample_ch1   <= shadow[1];
                                    sample_ch2   <= shadow[2];
                                    sample_ch3   <= shadow[3];
                                    sample_ch4   <= shadow[4];
                                    sample_ch5   <= shadow[5];
                                    sample_ch6   <= shadow[6];
                                    sample_ch7   <= in_data;
                                    ts_now       <= ts_frame;
                                    sample_valid <= 1'b1;
                                    state        <= StPublish;
                                end else begin
                                    shadow[exp_ch] <= in_data;
                                    exp_ch         <= exp_ch + 3'd1;
                                end
                            end else begin
                                if (seq_err_count != '1) seq_err_count <= seq_err_count + 16'd1;
                                state <= StIdle;
                            end
                        end else if (gap == TIMEOUT_CYCLES - 1) begin
                            // Gap would reach TIMEOUT_CYCLES on this edge: abort the frame.
                            gap   <= '0;
                            state <= StIdle;
                            if (timeout_count != '1) timeout_count <= timeout_count + 16'd1;
                        end else begin
                            gap <= gap + 32'd1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_home_inventory_snapshot_assembler.sv
// Directed bench for the snapshot assembler: clean frames, sequence errors, restart,
// timeout, enable drop, async reset, and a prescaled timestamp wrap on a second instance.
module tb_home_inventory_snapshot_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst2_n, snap_en, in_valid, in_valid2;
    logic [2:0]  in_ch;
    logic [31:0] in_data;

    logic        in_ready, sample_valid, in_ready2, sample_valid2;
    logic [31:0] ts_now, ts_counter, frame_count, ts_now2, ts_counter2, frame_count2;
    logic [15:0] seq_err_count, timeout_count, seq_err_count2, timeout_count2;
    logic [31:0] s  [8];
    logic [31:0] s2 [8];

    home_inventory_snapshot_assembler #(.TS_DIV(1), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .snap_en(snap_en), .in_valid(in_valid),
        .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
        .sample_valid(sample_valid), .ts_now(ts_now),
        .sample_ch0(s[0]), .sample_ch1(s[1]), .sample_ch2(s[2]), .sample_ch3(s[3]),
        .sample_ch4(s[4]), .sample_ch5(s[5]), .sample_ch6(s[6]), .sample_ch7(s[7]),
        .ts_counter(ts_counter), .frame_count(frame_count),
        .seq_err_count(seq_err_count), .timeout_count(timeout_count)
    );

    home_inventory_snapshot_assembler #(.TS_DIV(4), .TIMEOUT_CYCLES(16)) dut2 (
        .clk(clk), .rst_n(rst2_n), .snap_en(snap_en), .in_valid(in_valid2),
        .in_ready(in_ready2), .in_ch(in_ch), .in_data(in_data),
        .sample_valid(sample_valid2), .ts_now(ts_now2),
        .sample_ch0(s2[0]), .sample_ch1(s2[1]), .sample_ch2(s2[2]), .sample_ch3(s2[3]),
        .sample_ch4(s2[4]), .sample_ch5(s2[5]), .sample_ch6(s2[6]), .sample_ch7(s2[7]),
        .ts_counter(ts_counter2), .frame_count(frame_count2),
        .seq_err_count(seq_err_count2), .timeout_count(timeout_count2)
    );

    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    logic [31:0] tb_ts;
    logic [31:0] t_exp;

    // Expected timestamp for TS_DIV=1: edges seen since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + 32'd1;
    end

    always @(posedge clk) if (sample_valid) pulses <= pulses + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input int ch, input logic [31:0] d, input bit second);
        in_ch   = 3'(ch);
        in_data = d;
        if (second) in_valid2 = 1'b1;
        else        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base);
        for (int i = 0; i < 8; i++) send(i, base + 32'(i), 1'b0);
    endtask

    task automatic check_pub(input logic [31:0] base, input logic [31:0] ts_exp);
        check_eq("pub_valid", 32'(sample_valid), 32'd1);
        check_eq("pub_ready", 32'(in_ready), 32'd0);
        check_eq("pub_ts", ts_now, ts_exp);
        for (int i = 0; i < 8; i++) check_eq($sformatf("pub_ch%0d", i), s[i], base + 32'(i));
        @(negedge clk);
        check_eq("post_valid", 32'(sample_valid), 32'd0);
        check_eq("post_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0; snap_en = 1'b1;
        in_valid = 1'b0; in_valid2 = 1'b0; in_ch = '0; in_data = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        check_eq("rst_valid", 32'(sample_valid), 32'd0);
        check_eq("rst_ts", ts_counter, 32'd0);
        check_eq("rst_ch0", s[0], 32'd0);
        check_eq("rst_frames", frame_count, 32'd0);

        // Clean frame, ch0 accepted while ts_counter == 5
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("ts_at5", ts_counter, 32'd5);
        send_frame(32'h10);
        check_pub(32'h10, 32'd5);
        check_eq("frames1", frame_count, 32'd1);
        check_eq("pulses1", 32'(pulses), 32'd1);

        // Sequence error ch0, ch1, ch3
        send(0, 32'h30, 1'b0); send(1, 32'h31, 1'b0); send(3, 32'h33, 1'b0);
        check_eq("seq_err1", 32'(seq_err_count), 32'd1);
        check_eq("seq_hold_ch0", s[0], 32'h10);
        check_eq("seq_hold_ts", ts_now, 32'd5);
        t_exp = tb_ts;
        send_frame(32'h20);
        check_pub(32'h20, t_exp);
        check_eq("frames2", frame_count, 32'd2);

        // Early restart: second ch0 sets the timestamp
        send(0, 32'h40, 1'b0); send(1, 32'h41, 1'b0);
        t_exp = tb_ts;
        send(0, 32'h50, 1'b0);
        for (int i = 1; i < 8; i++) send(i, 32'h50 + 32'(i), 1'b0);
        check_pub(32'h50, t_exp);
        check_eq("seq_err2", 32'(seq_err_count), 32'd2);
        check_eq("frames3", frame_count, 32'd3);

        // Timeout after 16 idle cycles, not 15
        for (int i = 0; i < 4; i++) send(i, 32'h60 + 32'(i), 1'b0);
        repeat (15) @(negedge clk);
        check_eq("to_before", 32'(timeout_count), 32'd0);
        @(negedge clk);
        check_eq("to_after", 32'(timeout_count), 32'd1);
        check_eq("to_pulses", 32'(pulses), 32'd3);
        t_exp = tb_ts;
        send_frame(32'h70);
        check_pub(32'h70, t_exp);
        check_eq("frames4", frame_count, 32'd4);

        // Enable drop after ch4; word during disable is dropped silently
        for (int i = 0; i < 5; i++) send(i, 32'h80 + 32'(i), 1'b0);
        snap_en = 1'b0;
        @(negedge clk);
        send(5, 32'h85, 1'b0);
        snap_en = 1'b1;
        check_eq("en_seq", 32'(seq_err_count), 32'd2);
        check_eq("en_to", 32'(timeout_count), 32'd1);
        check_eq("en_hold", s[0], 32'h70);
        t_exp = tb_ts;
        send_frame(32'h90);
        check_pub(32'h90, t_exp);
        check_eq("en_seq_after", 32'(seq_err_count), 32'd2);
        check_eq("frames5", frame_count, 32'd5);

        // Accept in the would-be timeout cycle wins
        t_exp = tb_ts;
        send(0, 32'hB0, 1'b0);
        repeat (15) @(negedge clk);
        for (int i = 1; i < 8; i++) send(i, 32'hB0 + 32'(i), 1'b0);
        check_pub(32'hB0, t_exp);
        check_eq("to_edge_cnt", 32'(timeout_count), 32'd1);
        check_eq("frames6", frame_count, 32'd6);

        // Async reset mid-frame, not clock-aligned
        for (int i = 0; i < 3; i++) send(i, 32'hC0 + 32'(i), 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check_eq("ar_frames", frame_count, 32'd0);
        check_eq("ar_ch7", s[7], 32'd0);
        check_eq("ar_ts", ts_counter, 32'd0);
        check_eq("ar_tsnow", ts_now, 32'd0);
        check_eq("ar_seq", 32'(seq_err_count), 32'd0);
        check_eq("ar_to", 32'(timeout_count), 32'd0);
        check_eq("ar_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("ar_no_pulse", 32'(pulses), 32'd6);

        // TS_DIV=4 instance: preload near wrap, check prescale and wrap
        rst2_n = 1'b1;
        force dut2.ts_counter = 32'hFFFF_FFFE;
        release dut2.ts_counter;
        repeat (3) @(negedge clk);
        check_eq("w_hold", ts_counter2, 32'hFFFF_FFFE);
        @(negedge clk);
        check_eq("w_step", ts_counter2, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) send(i, 32'hA0 + 32'(i), 1'b1);
        check_eq("w_wrap", ts_counter2, 32'd0);
        for (int i = 4; i < 8; i++) send(i, 32'hA0 + 32'(i), 1'b1);
        check_eq("w_valid", 32'(sample_valid2), 32'd1);
        check_eq("w_tsnow", ts_now2, 32'hFFFF_FFFF);
        check_eq("w_ch0", s2[0], 32'hA0);
        check_eq("w_ch7", s2[7], 32'hA7);
        check_eq("w_ts1", ts_counter2, 32'd1);
        @(negedge clk);
        check_eq("w_frames", frame_count2, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
